// File: rtl/enemy_formation.sv
// Purpose: N_ROWS x N_COLS enemy formation; marches, descends, resolves shot hits, draws one RGB pixel per VGA position.
// Latency: hit_ack/hit_index and pixel_on/RGB are registered, one cycle after the sampled inputs; alive/alive_count/all_dead are combinational from the mask register.
// Backpressure: none; a hit_valid strobe is accepted every cycle and the pixel path follows h_counter/v_counter every cycle.
module enemy_formation #(
    parameter int          N_COLS     = 8,
    parameter int          N_ROWS     = 2,
    parameter int          START_X    = 50,
    parameter int          START_Y    = 50,
    parameter int          SPACING_X  = 50,
    parameter int          SPACING_Y  = 40,
    parameter int          SPRITE_W   = 32,
    parameter int          SPRITE_H   = 24,
    parameter int          STEP_X     = 8,
    parameter int          STEP_Y     = 16,
    parameter int          X_MIN      = 8,
    parameter int          X_MAX      = 639,
    parameter int          FLOOR_Y    = 440,
    parameter int          MOVE_DIV   = 30,
    parameter logic [23:0] COLOR_EVEN = 24'hFF0000,
    parameter logic [23:0] COLOR_ODD  = 24'h00FF00
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   frame_tick,
    input  logic                                   game_restart,
    input  logic [9:0]                             h_counter,
    input  logic [9:0]                             v_counter,
    input  logic                                   hit_valid,
    input  logic [9:0]                             hit_x,
    input  logic [9:0]                             hit_y,
    output logic                                   hit_ack,
    output logic [$clog2(N_ROWS*N_COLS)-1:0]       hit_index,
    output logic [N_ROWS*N_COLS-1:0]               alive,
    output logic [$clog2(N_ROWS*N_COLS+1)-1:0]     alive_count,
    output logic                                   all_dead,
    output logic                                   reached_floor,
    output logic                                   pixel_on,
    output logic [7:0]                             R,
    output logic [7:0]                             G,
    output logic [7:0]                             B
);

    localparam int N   = N_ROWS * N_COLS;
    localparam int IW  = $clog2(N);
    localparam int CW  = $clog2(N + 1);
    localparam int CIW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int RIW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int DW  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    // 12-bit constants so edge sums never silently wrap during comparisons
    localparam logic [11:0] SX12 = 12'(SPACING_X);
    localparam logic [11:0] SY12 = 12'(SPACING_Y);

    typedef enum logic [1:0] {
        MARCH_R = 2'd0,
        MARCH_L = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [10:0]     base_x;
    logic [10:0]     base_y;
    logic [10:0]     base_x_nxt;
    logic [10:0]     base_y_nxt;
    logic [N-1:0]    alive_q;
    logic [N-1:0]    alive_nxt;
    logic [DW-1:0]   div;
    logic            step;
    logic            floor_set;
    logic [IW:0]     hit_res;
    logic            hit_fire;
    logic [IW:0]     pix_res;
    logic [23:0]     pix_color;
    logic [N_COLS-1:0] col_alive;
    logic [N_ROWS-1:0] row_alive;
    logic [CIW-1:0]  cmin;
    logic [CIW-1:0]  cmax;
    logic [RIW-1:0]  rmax;
    logic [11:0]     right_edge;
    logic [11:0]     left_edge;
    logic [11:0]     bottom_edge;
    logic [CW-1:0]   count;

    // Lowest-index alive enemy whose sprite box contains (px,py); returns {found, index}.
    function automatic logic [IW:0] locate(input logic [10:0] px, input logic [10:0] py,
                                           input logic [10:0] bx, input logic [10:0] by,
                                           input logic [N-1:0] msk);
        logic [IW:0] res;
        logic [10:0] x0;
        logic [10:0] y0;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            x0 = bx + 11'((i % N_COLS) * SPACING_X);
            y0 = by + 11'((i / N_COLS) * SPACING_Y);
            if (msk[IW'(i)] && (px >= x0) && (px < x0 + 11'(SPRITE_W)) &&
                (py >= y0) && (py < y0 + 11'(SPRITE_H))) begin
                res = {1'b1, IW'(i)};
            end
        end
        return res;
    endfunction

    assign alive       = alive_q;
    assign all_dead    = (alive_q == '0);
    assign alive_count = count;
    assign step        = frame_tick && (div == DW'(MOVE_DIV - 1));

    // Shot resolution against the positions held this cycle; the mask used for movement already excludes the victim
    always_comb begin
        hit_res   = locate({1'b0, hit_x}, {1'b0, hit_y}, base_x, base_y, alive_q);
        hit_fire  = hit_valid && hit_res[IW];
        alive_nxt = alive_q;
        if (hit_fire) begin
            alive_nxt[hit_res[IW-1:0]] = 1'b0;
        end
    end

    // Extremes of the surviving formation: outermost occupied columns and lowest occupied row
    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int i = 0; i < N; i++) begin
            if (alive_nxt[IW'(i)]) begin
                col_alive[CIW'(i % N_COLS)] = 1'b1;
                row_alive[RIW'(i / N_COLS)] = 1'b1;
            end
        end
        cmin = '0;
        cmax = '0;
        rmax = '0;
        for (int c = N_COLS - 1; c >= 0; c--) begin
            if (col_alive[CIW'(c)]) cmin = CIW'(c);
        end
        for (int c = 0; c < N_COLS; c++) begin
            if (col_alive[CIW'(c)]) cmax = CIW'(c);
        end
        for (int r = 0; r < N_ROWS; r++) begin
            if (row_alive[RIW'(r)]) rmax = RIW'(r);
        end
    end

    // Formation state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MARCH_R;
        end else if (game_restart) begin
            state <= MARCH_R;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and base position: march, reverse with a descent at an edge, halt at the floor or when empty
    always_comb begin
        state_nxt   = state;
        base_x_nxt  = base_x;
        base_y_nxt  = base_y;
        floor_set   = 1'b0;
        right_edge  = {1'b0, base_x} + 12'(cmax) * SX12 + 12'(SPRITE_W - 1) + 12'(STEP_X);
        left_edge   = {1'b0, base_x} + 12'(cmin) * SX12;
        bottom_edge = '0;
        if (state != HALT) begin
            if (all_dead) begin
                state_nxt = HALT;
            end else if (step && (alive_nxt != '0)) begin
                case (state)
                    MARCH_R: begin
                        if (right_edge <= 12'(X_MAX)) begin
                            base_x_nxt = base_x + 11'(STEP_X);
                        end else begin
                            base_y_nxt = base_y + 11'(STEP_Y);
                            state_nxt  = MARCH_L;
                        end
                    end
                    MARCH_L: begin
                        if (left_edge >= 12'(X_MIN + STEP_X)) begin
                            base_x_nxt = base_x - 11'(STEP_X);
                        end else begin
                            base_y_nxt = base_y + 11'(STEP_Y);
                            state_nxt  = MARCH_R;
                        end
                    end
                    default: ;
                endcase
                bottom_edge = {1'b0, base_y_nxt} + 12'(rmax) * SY12 + 12'(SPRITE_H - 1);
                if (bottom_edge >= 12'(FLOOR_Y)) begin
                    floor_set = 1'b1;
                    state_nxt = HALT;
                end
            end
        end
    end

    // Position, alive mask, frame divider, invasion flag and hit acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_x        <= 11'(START_X);
            base_y        <= 11'(START_Y);
            alive_q       <= '1;
            div           <= '0;
            reached_floor <= 1'b0;
            hit_ack       <= 1'b0;
            hit_index     <= '0;
        end else if (game_restart) begin
            base_x        <= 11'(START_X);
            base_y        <= 11'(START_Y);
            alive_q       <= '1;
            div           <= '0;
            reached_floor <= 1'b0;
            hit_ack       <= 1'b0;
            hit_index     <= '0;
        end else begin
            base_x  <= base_x_nxt;
            base_y  <= base_y_nxt;
            alive_q <= alive_nxt;
            if (frame_tick) begin
                div <= step ? '0 : div + DW'(1);
            end
            if (floor_set) begin
                reached_floor <= 1'b1;
            end
            hit_ack <= hit_fire;
            if (hit_fire) begin
                hit_index <= hit_res[IW-1:0];
            end
        end
    end

    // Pixel lookup: winning enemy and its row colour
    always_comb begin
        pix_res   = locate({1'b0, h_counter}, {1'b0, v_counter}, base_x, base_y, alive_q);
        pix_color = '0;
        if (pix_res[IW]) begin
            pix_color = (((int'(pix_res[IW-1:0]) / N_COLS) % 2) == 0) ? COLOR_EVEN : COLOR_ODD;
        end
    end

    // Registered pixel output; keeps drawing in HALT so the formation stays visible
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_on  <= 1'b0;
            {R, G, B} <= 24'h0;
        end else if (game_restart) begin
            pixel_on  <= 1'b0;
            {R, G, B} <= 24'h0;
        end else begin
            pixel_on  <= pix_res[IW];
            {R, G, B} <= pix_color;
        end
    end

    // Population count of the live mask
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(alive_q[IW'(i)]);
        end
    end

endmodule

// File: doc/enemy_formation.md
Name: enemy_formation

Overview:
- Parametrised successor to the fixed 8-enemy row: an N_ROWS x N_COLS enemy grid whose formation marches horizontally, steps down and reverses at the screen edges.
- Tracks per-enemy alive state, resolves shot hits against the live grid, and produces one priority-resolved RGB pixel per VGA counter position.
- Sits between the vga timing block (h_counter/v_counter, frame tick) and the top-level colour mux.

Parameters:
N_COLS, 8, enemies per row
N_ROWS, 2, rows
START_X, 50, reset base_x (left edge of column 0)
START_Y, 50, reset base_y (top edge of row 0)
SPACING_X, 50, column pitch in pixels
SPACING_Y, 40, row pitch in pixels
SPRITE_W, 32, enemy width
SPRITE_H, 24, enemy height
STEP_X, 8, horizontal pixels per march step
STEP_Y, 16, vertical pixels per descend step
X_MIN, 8, leftmost legal pixel
X_MAX, 639, rightmost legal pixel
FLOOR_Y, 440, invasion line
MOVE_DIV, 30, frame_ticks per formation step (>=1)
COLOR_EVEN, 24'hFF0000, RGB for even rows
COLOR_ODD, 24'h00FF00, RGB for odd rows

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per frame, from the vga block
game_restart  in  1  synchronous restart; same effect as reset
h_counter  in  10  current pixel x
v_counter  in  10  current pixel y
hit_valid  in  1  shot-position strobe
hit_x  in  10  shot x
hit_y  in  10  shot y
hit_ack  out  1  one-cycle pulse: an enemy was destroyed
hit_index  out  clog2(N)  index of the destroyed enemy (N = N_ROWS*N_COLS)
alive  out  N  alive mask; bit r*N_COLS+c
alive_count  out  clog2(N+1)  popcount of alive
all_dead  out  1  alive == 0
reached_floor  out  1  sticky invasion flag
pixel_on  out  1  an enemy covers the pixel
R  out  8  pixel red
G  out  8  pixel green
B  out  8  pixel blue

Behaviour:
- Geometry: enemy (r,c) has x0 = base_x + c*SPACING_X and y0 = base_y + r*SPACING_Y. Containment is x0 <= px < x0+SPRITE_W and y0 <= py < y0+SPRITE_H. All arithmetic is 11-bit unsigned; no wrap.
- Reset or game_restart:
  - base_x = START_X, base_y = START_Y, alive = all ones, state MARCH_R, divider = 0.
  - hit_ack = 0, hit_index = 0, reached_floor = 0, pixel_on = 0, RGB = 0.
- Divider: counts frame_ticks. When it reaches MOVE_DIV-1 on a frame_tick, it wraps to 0 and issues step.
- State machine (states MARCH_R, MARCH_L, HALT):
  - cmin/cmax are the leftmost/rightmost columns containing an alive enemy; rmax is the lowest alive row.
  - MARCH_R, on step: if base_x + cmax*SPACING_X + SPRITE_W-1 + STEP_X <= X_MAX, then base_x += STEP_X. Otherwise base_y += STEP_Y, go to MARCH_L, with no horizontal move that step.
  - MARCH_L, on step: if base_x + cmin*SPACING_X >= X_MIN + STEP_X, then base_x -= STEP_X. Otherwise base_y += STEP_Y, go to MARCH_R.
  - After any update, if base_y + rmax*SPACING_Y + SPRITE_H-1 >= FLOOR_Y: set reached_floor and go to HALT.
  - all_dead forces HALT on the next cycle.
  - HALT: no movement; only reset or game_restart leave it.
- Hits:
  - hit_valid is sampled at posedge and evaluated against the pre-update base_x/base_y of that cycle.
  - The lowest-index alive enemy containing (hit_x,hit_y) is cleared. hit_ack pulses the next cycle with hit_index.
  - A miss, a dead enemy, or HALT due to all_dead produces no ack.
  - A hit and a step in the same cycle both apply: hit against old positions, move with the new alive mask excluded.
  - Back-to-back hit_valid is accepted every cycle.
- Pixel path:
  - Registered, latency 1 cycle from h_counter/v_counter.
  - The lowest-index alive containing enemy wins; colour is COLOR_EVEN or COLOR_ODD by row parity.
  - With no enemy, pixel_on = 0 and RGB = 0.
  - Pixels are drawn in HALT too, because the formation stays visible.
- alive_count, all_dead and alive are combinational from the registered mask.
- Asserting reset mid-frame clears immediately (asynchronous). Deassertion is sampled at clk.

Test Plan:
- Reset, defaults -> alive = 16'hFFFF, alive_count = 16, base 50/50, pixel at (50,50) one cycle later gives R=FF G=00 B=00; pixel at (82,50) gives pixel_on = 0.
- 30 frame_ticks -> exactly one step, base_x = 58; 29 ticks -> base_x still 50.
- 26 steps -> base_x = 258 in MARCH_R; 27th step -> base_x = 258, base_y = 66, state MARCH_L; 28th step -> base_x = 250.
- Hit at (100,90) -> hit_ack next cycle, hit_index = 9, bit 9 cleared, alive_count = 15. Repeat the same hit -> no ack.
- Kill columns 6-7 in both rows, then march -> reversal occurs when the column-5 right edge would exceed 639.
- Force descents until the row-1 bottom reaches 440 -> reached_floor = 1, HALT, later ticks leave base unchanged. Kill all 16 -> all_dead = 1. game_restart -> full reset values.
